carry_look_ahead_pipe: RTL and testbench
========================================

CARRY_LOOK_AHEAD_PIPE -- requirements
Module: carry_look_ahead_pipe

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning total operand width in bits.
REQ-002 The block SHALL have parameter K, default 8, meaning the CLA block width per pipeline stage; N SHALL be an integer multiple of K, and STAGES = N/K.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set on A, B, C_in and SUB is valid this cycle.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 A  input  N  first operand.
REQ-008 B  input  N  second operand.
REQ-009 C_in  input  1  carry-in, used only when SUB=0.
REQ-010 SUB  input  1  0 = A+B+C_in; 1 = A-B, computed as A+~B+1 with C_in ignored.
REQ-011 out_valid  output  1  S and the flags hold a valid result.
REQ-012 out_ready  input  1  downstream consumes the result this cycle.
REQ-013 S  output  N  sum or difference, modulo 2^N.
REQ-014 C_out  output  1  carry out of bit N-1; for SUB, 1 means no borrow (A >= B unsigned).
REQ-015 V  output  1  two's-complement signed overflow.
REQ-016 Z  output  1  1 when S == 0.

Function
REQ-017 The block SHALL split each operation into STAGES slices of K bits. Stage i SHALL compute bits [iK+K-1:iK] with K-bit carry-lookahead logic (generate/propagate, no ripple inside a slice) and SHALL register the carry out of the slice for stage i+1.
REQ-018 Operand slices not yet consumed SHALL travel in skew registers alongside the operation, and result slices already computed SHALL travel in de-skew registers, so S is presented complete and aligned.
REQ-019 Each stage SHALL hold a valid bit. The global advance enable SHALL be adv = !out_valid || out_ready, and every pipeline register SHALL update only when adv=1.
REQ-020 in_ready SHALL equal adv while reset=0, and SHALL be 0 while reset=1. An operation is accepted in a cycle with in_valid && in_ready.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when not stalled. Throughput SHALL be one operation per cycle.
REQ-022 When out_valid=1 and out_ready=0, S, C_out, V, Z and all internal stages SHALL hold unchanged. No operation SHALL be lost, duplicated or reordered.
REQ-023 A bubble (in_valid=0 while in_ready=1) SHALL propagate as an invalid stage. Bubbles SHALL NOT stall valid operations ahead of them.
REQ-024 V SHALL be computed as carry into bit N-1 XOR carry out of bit N-1, using the effective B (~B when SUB=1).
REQ-025 Z SHALL be computed from the full aligned N-bit S of the same operation.
REQ-026 When STAGES=1, the block SHALL behave as a single registered CLA with latency 1.
REQ-027 A new operation MAY be accepted in the same cycle that a result is consumed.

Reset
REQ-028 While reset=1 at a clock edge, all stage valid bits and out_valid SHALL clear to 0, and S, C_out, V, Z SHALL clear to 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations. The first out_valid after reset deasserts SHALL belong to an operation accepted after that deassertion.
REQ-030 Skew and de-skew data registers SHALL also clear to 0, so no X state is visible on the outputs.

Verification (N=32, K=8, out_ready=1 unless stated)
REQ-031 A=0x00000001, B=0x00000001, C_in=0, SUB=0 -> 4 cycles later: out_valid=1, S=0x00000002, C_out=0, V=0, Z=0.
REQ-032 A=0xFFFFFFFF, B=0x00000001, C_in=0 -> S=0x00000000, C_out=1, V=0, Z=1. Also A=0xFFFF0000, B=0x0000FFFF, C_in=1 -> S=0x00000000, C_out=1, Z=1; this checks carry crossing all 4 stage boundaries.
REQ-033 A=0x7FFFFFFF, B=0x00000001, SUB=0 -> S=0x80000000, V=1, C_out=0. Then A=0x00000005, B=0x00000007, SUB=1, C_in=1 -> S=0xFFFFFFFE, C_out=0, V=0 (C_in ignored).
REQ-034 Stream 6 back-to-back operations (including 0x12345678+0x87654321 -> 0x99999999 and 0x0F0F0F0F+0xF0F0F0F0+1 -> 0x00000000, C_out=1). Hold out_ready=0 for 3 cycles mid-stream. Required: in_ready=0 while stalled, outputs frozen, all 6 results appear in order with no loss.
REQ-035 Accept 2 operations, then assert reset for 1 cycle at the next edge -> out_valid stays 0 and no stale result appears. A subsequent operation 3+4 yields S=0x00000007 exactly 4 cycles after acceptance.
REQ-036 Instantiate with N=16, K=16 -> 0xFFFF+0x0001 yields S=0x0000, C_out=1, Z=1, with latency 1.

Source files
------------

// File: rtl/carry_look_ahead_pipe.sv
// carry_look_ahead_pipe
//
// Pipelined adder/subtractor. The N-bit operation is cut into STAGES = N/K
// slices of K bits. Each stage adds one slice with flat carry-lookahead logic
// and registers the slice carry for the next stage. Unconsumed operand bits
// ride along in skew registers, and already-computed sum slices ride along in
// de-skew registers, so the final stage presents a complete, aligned result.
// One global advance enable (adv) moves the whole pipe, so a stalled output
// freezes every stage. Bubbles travel as invalid stages.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears all stages and outputs
//   in_valid   operand set on A/B/C_in/SUB is valid
//   in_ready   operand set is accepted this cycle (in_valid && in_ready)
//   A, B       N-bit operands
//   C_in       carry-in, used only when SUB=0
//   SUB        0: A+B+C_in, 1: A-B computed as A+~B+1 (C_in ignored)
//   out_valid  S and flags hold a valid result
//   out_ready  downstream consumes the result this cycle
//   S          N-bit sum/difference
//   C_out      carry out of bit N-1 (for SUB: 1 = no borrow)
//   V          signed overflow
//   Z          S == 0
module carry_look_ahead_pipe #(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_in,
    input  logic         SUB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         C_out,
    output logic         V,
    output logic         Z
);

    localparam int STAGES = N / K;

    // K-bit carry-lookahead slice. Every carry is a flat sum of products of
    // generate/propagate terms and the slice carry-in, so nothing ripples.
    // Returns {carry out of the slice, carry into the slice MSB, sum}.
    function automatic logic [K+1:0] cla_slice(
        input logic [K-1:0] a,
        input logic [K-1:0] b,
        input logic         c0
    );
        logic [K-1:0] g;
        logic [K-1:0] p;
        logic [K:0]   c;
        logic [K-1:0] s;
        logic         pp;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c0;
        for (int j = 0; j < K; j++) begin
            c[j+1] = g[j];
            pp     = p[j];
            for (int m = j - 1; m >= 0; m--) begin
                c[j+1] = c[j+1] | (pp & g[m]);
                pp     = pp & p[m];
            end
            c[j+1] = c[j+1] | (pp & c0);
        end
        s = p ^ c[K-1:0];
        return {c[K], c[K-1], s};
    endfunction

    logic                     adv;
    logic [STAGES-1:0]        vld_q, vld_d;
    logic [STAGES-1:0]        carry_q, carry_d;
    logic [STAGES-1:0][N-1:0] a_q, a_d;
    logic [STAGES-1:0][N-1:0] b_q, b_d;
    logic [STAGES-1:0][N-1:0] s_q, s_d;
    logic                     v_q, v_d;
    logic                     z_q, z_d;
    logic [N-1:0]             b_eff;
    logic                     c_first;
    logic [K+1:0]             slice_r;
    logic                     unused_skew;

    assign adv       = !vld_q[STAGES-1] || out_ready;
    assign in_ready  = adv && !reset;
    assign out_valid = vld_q[STAGES-1];
    assign S         = s_q[STAGES-1];
    assign C_out     = carry_q[STAGES-1];
    assign V         = v_q;
    assign Z         = z_q;

    // Subtraction is folded into the operand: effective B is ~B and the
    // carry-in is forced to 1, so the whole pipe only ever adds.
    assign b_eff   = SUB ? ~B : B;
    assign c_first = SUB ? 1'b1 : C_in;

    // Operands are fully consumed by the last stage; its skew copy is dead.
    assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1]};

    always_comb begin
        vld_d   = vld_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        v_d     = v_q;
        z_d     = z_q;
        slice_r = '0;
        if (adv) begin
            // Stage 0: lowest slice straight from the ports
            slice_r         = cla_slice(A[K-1:0], b_eff[K-1:0], c_first);
            vld_d[0]        = in_valid;
            a_d[0]          = A;
            b_d[0]          = b_eff;
            s_d[0]          = '0;
            s_d[0][K-1:0]   = slice_r[K-1:0];
            carry_d[0]      = slice_r[K+1];
            // Stage i: slice i from the skewed operands and the registered carry
            for (int i = 1; i < STAGES; i++) begin
                slice_r = cla_slice(a_q[i-1][i*K +: K], b_q[i-1][i*K +: K],
                                    carry_q[i-1]);
                vld_d[i]          = vld_q[i-1];
                a_d[i]            = a_q[i-1];
                b_d[i]            = b_q[i-1];
                s_d[i]            = s_q[i-1];
                s_d[i][i*K +: K]  = slice_r[K-1:0];
                carry_d[i]        = slice_r[K+1];
            end
            // slice_r now holds the top slice: carry into bit N-1 vs carry out
            v_d = slice_r[K+1] ^ slice_r[K];
            z_d = ~|s_d[STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q   <= '0;
            carry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

endmodule

// File: tb/tb_carry_look_ahead_pipe.sv
// Bench for carry_look_ahead_pipe: a 32/8 instance (4 stages) and a 16/16
// instance (single stage). Expected results are queued at acceptance and
// compared when each instance presents a result.
module tb_carry_look_ahead_pipe;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, C_in, SUB, out_valid, out_ready;
    logic [31:0] A, B, S;
    logic        C_out, V, Z;

    logic        in_valid2, in_ready2, C_in2, SUB2, out_valid2, out_ready2;
    logic [15:0] A2, B2, S2;
    logic        C_out2, V2, Z2;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_lo = -1;
    int   stall_hi = -1;
    bit   rnd_mode = 0;
    logic nxt_reset;
    logic nxt_iv2;
    logic [15:0] nxt_a2, nxt_b2;
    exp_t q[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    carry_look_ahead_pipe #(.N(32), .K(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .C_in(C_in), .SUB(SUB), .out_valid(out_valid),
        .out_ready(out_ready), .S(S), .C_out(C_out), .V(V), .Z(Z)
    );

    carry_look_ahead_pipe #(.N(16), .K(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(A2), .B(B2), .C_in(C_in2), .SUB(SUB2), .out_valid(out_valid2),
        .out_ready(out_ready2), .S(S2), .C_out(C_out2), .V(V2), .Z(Z2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b,
                                     input logic ci, input logic sb);
        exp_t        m;
        logic [31:0] be;
        logic [32:0] t;
        be    = sb ? ~b : b;
        t     = {1'b0, a} + {1'b0, be} + {32'd0, (sb ? 1'b1 : ci)};
        m.s   = t[31:0];
        m.c   = t[32];
        m.v   = (a[31] == be[31]) && (t[31] != a[31]);
        m.z   = (t[31:0] == 32'd0);
        m.due = 0;
        return m;
    endfunction

    function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b);
        exp_t        m;
        logic [16:0] t;
        t     = {1'b0, a} + {1'b0, b};
        m.s   = {16'd0, t[15:0]};
        m.c   = t[16];
        m.v   = (a[15] == b[15]) && (t[15] != a[15]);
        m.z   = (t[15:0] == 16'd0);
        m.due = 0;
        return m;
    endfunction

    // One clock: drive at the falling edge, then check what is on the outputs
    // and record whether the coming rising edge accepts the operand set.
    task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb, output logic acc);
        exp_t e;
        @(negedge clk);
        cyc++;
        reset     = nxt_reset;
        in_valid  = iv;
        A         = a;
        B         = b;
        C_in      = ci;
        SUB       = sb;
        out_ready = rnd_mode ? ($urandom_range(3) != 0)
                             : !(cyc >= stall_lo && cyc < stall_hi);
        in_valid2 = nxt_iv2;
        A2        = nxt_a2;
        B2        = nxt_b2;
        #1;
        acc = 1'b0;
        if (reset) begin
            q.delete();
            q2.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    chk("S", {32'd0, S}, {32'd0, q[0].s});
                    chk("C_out", {63'd0, C_out}, {63'd0, q[0].c});
                    chk("V", {63'd0, V}, {63'd0, q[0].v});
                    chk("Z", {63'd0, Z}, {63'd0, q[0].z});
                    chk("latency", 64'(cyc), 64'(q[0].due));
                    if (out_ready) begin
                        void'(q.pop_front());
                    end else begin
                        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                        foreach (q[i]) q[i].due++;
                    end
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                chk("missing_result", {63'd0, out_valid}, 64'd1);
            end
            acc = iv && in_ready;
            if (acc) begin
                e     = model32(a, b, ci, sb);
                e.due = cyc + 4;
                q.push_back(e);
            end

            if (out_valid2) begin
                if (q2.size() == 0) begin
                    chk("spurious_out_valid16", {63'd0, out_valid2}, 64'd0);
                end else begin
                    chk("S16", {48'd0, S2}, {32'd0, q2[0].s});
                    chk("C_out16", {63'd0, C_out2}, {63'd0, q2[0].c});
                    chk("V16", {63'd0, V2}, {63'd0, q2[0].v});
                    chk("Z16", {63'd0, Z2}, {63'd0, q2[0].z});
                    chk("latency16", 64'(cyc), 64'(q2[0].due));
                    void'(q2.pop_front());
                end
            end else if (q2.size() != 0 && q2[0].due <= cyc) begin
                chk("missing_result16", {63'd0, out_valid2}, 64'd1);
            end
            if (in_valid2 && in_ready2) begin
                e     = model16(A2, B2);
                e.due = cyc + 1;
                q2.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            cycle(1'b1, a, b, ci, sb, acc);
            tries++;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || q2.size() != 0) && n < 60) begin
            idle(1);
            n++;
        end
        if (q.size() != 0 || q2.size() != 0)
            chk("drain_timeout", 64'(q.size() + q2.size()), 64'd0);
    endtask

    logic [31:0] stream_a [6] = '{32'h12345678, 32'h0F0F0F0F, 32'h00000010, 32'hFFFFFFFF, 32'h80000000, 32'h00000003};
    logic [31:0] stream_b [6] = '{32'h87654321, 32'hF0F0F0F0, 32'h00000020, 32'hFFFFFFFF, 32'h00000001, 32'h00000009};
    logic        stream_c [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        stream_s [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        reset     = 1'b1;
        nxt_reset = 1'b1;
        in_valid  = 1'b0;
        A = '0; B = '0; C_in = 1'b0; SUB = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; A2 = '0; B2 = '0; C_in2 = 1'b0; SUB2 = 1'b0; out_ready2 = 1'b1;
        nxt_iv2 = 1'b0; nxt_a2 = '0; nxt_b2 = '0;

        idle(2);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_S", {32'd0, S}, 64'd0);
        chk("rst_flags", {61'd0, C_out, V, Z}, 64'd0);
        nxt_reset = 1'b0;

        // Basic add, carry across all slice boundaries, overflow, subtract
        send(32'h00000001, 32'h00000001, 1'b0, 1'b0);
        drain();
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        send(32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0);
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        send(32'h00000005, 32'h00000007, 1'b1, 1'b1);
        drain();

        // Back-to-back stream with a 3-cycle output stall in the middle
        stall_lo = cyc + 6;
        stall_hi = stall_lo + 3;
        for (int i = 0; i < 6; i++) send(stream_a[i], stream_b[i], stream_c[i], stream_s[i]);
        drain();
        stall_lo = -1;
        stall_hi = -1;

        // Reset with two operations in flight
        send(32'h00000011, 32'h00000022, 1'b0, 1'b0);
        send(32'h00000033, 32'h00000044, 1'b0, 1'b0);
        nxt_reset = 1'b1;
        idle(1);
        nxt_reset = 1'b0;
        idle(1);
        chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        idle(5);
        send(32'h00000003, 32'h00000004, 1'b0, 1'b0);
        drain();

        // Single-stage instance
        nxt_iv2 = 1'b1; nxt_a2 = 16'hFFFF; nxt_b2 = 16'h0001;
        idle(1);
        nxt_iv2 = 1'b1; nxt_a2 = 16'h7FFF; nxt_b2 = 16'h0001;
        idle(1);
        nxt_iv2 = 1'b0; nxt_a2 = '0; nxt_b2 = '0;
        drain();

        // Random traffic with random backpressure
        rnd_mode = 1;
        for (int i = 0; i < 30; i++)
            send($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
        rnd_mode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
